smvm_stream_tx: RTL and testbench

Transmit-side driver for the sparse matrix-vector multiply core's serial input interface. A host loads the dense vector and the list of nonzero entries into internal buffers. On start, the block serializes them onto the core's input bus as one continuous in_valid burst: header, vector, then value/index pairs padded to a multiple of K. It then holds the bus idle for a guard gap, so back-to-back jobs never violate the core's CAL/OUT recovery time.

---
 rtl/smvm_pkg.sv | 59 +++++
 rtl/smvm_nz_buffer.sv | 67 ++++++
 rtl/smvm_stream_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_smvm_stream_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smvm_pkg.sv
// Shared constants, state encoding and bus-word helpers for the SMVM stream driver.
// GAP_CYCLES is derived from the core's stall count so the guard gap tracks the core.
package smvm_pkg;
   localparam int K           = 4;
   localparam int VEC_DEPTH   = 128;
   localparam int NZ_DEPTH    = 256;
   localparam int CORE_STALL  = 5;
   localparam int GAP_CYCLES  = CORE_STALL + 3;

   localparam int WORD_W = 12;
   localparam int VA_W   = $clog2(VEC_DEPTH);
   localparam int NZ_AW  = $clog2(NZ_DEPTH);
   localparam int NZ_CW  = $clog2(NZ_DEPTH + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR_R,
      S_HDR_C,
      S_VEC,
      S_NZ_V,
      S_NZ_I,
      S_PAD_V,
      S_PAD_I,
      S_GAP
   } tx_state_e;

   typedef struct packed {
      logic [7:0] val;
      logic       ipv;
      logic [2:0] col;
   } word_t;

   typedef struct packed {
      logic [7:0]        val;
      logic              ipv;
      logic [WORD_W-1:0] col;
   } nz_ent_t;

   localparam int NZ_EW = $bits(nz_ent_t);

   function automatic word_t word_split(input logic [WORD_W-1:0] w);
      word_t r;
      r.val = w[11:4];
      r.ipv = w[3];
      r.col = w[2:0];
      return r;
   endfunction

   function automatic logic [WORD_W-1:0] word_join(input word_t w);
      return {w.val, w.ipv, w.col};
   endfunction

   // Zero pairs needed to round the entry count up to a multiple of K.
   function automatic logic [NZ_CW-1:0] calc_pad(input logic [NZ_CW-1:0] n);
      int r;
      r = (K - (int'(n) % K)) % K;
      return NZ_CW'(r);
   endfunction
endpackage

// File: rtl/smvm_nz_buffer.sv
// Append-only nonzero entry store with a sequential read port.
// rd_first rewinds to entry 0; rd_next fetches the following entry; data lands one cycle later.
module smvm_nz_buffer
   import smvm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [NZ_EW-1:0] wr_data,
   input  logic             clr,
   input  logic             rd_first,
   input  logic             rd_next,
   output logic [NZ_EW-1:0] rd_data,
   output logic [NZ_CW-1:0] count,
   output logic             full
);
   logic [NZ_EW-1:0] mem [NZ_DEPTH];
   logic [NZ_EW-1:0] rd_data_q;
   logic [NZ_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [NZ_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [NZ_AW-1:0] rd_addr;
   logic [NZ_CW-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             wr_ok;
   logic             rd_en;

   always_comb begin
      wr_ok    = wr_en && !full_q;
      rd_en    = rd_first || rd_next;
      rd_addr  = rd_first ? '0 : rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      if (clr) begin
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + NZ_AW'(1);
         count_d  = count_q + NZ_CW'(1);
      end
      if (rd_en) rd_ptr_d = rd_addr + NZ_AW'(1);
      full_d = (count_d == NZ_CW'(NZ_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_q] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   assign rd_data = rd_data_q;
   assign count   = count_q;
   assign full    = full_q;
endmodule

// File: rtl/smvm_stream_tx.sv
// Serializes header, dense vector and padded nonzero pairs onto the SMVM core input bus,
// then holds a guard gap before signalling done.
module smvm_stream_tx
   import smvm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vec_we,
   input  logic [VA_W-1:0]   vec_addr,
   input  logic [7:0]        vec_wdata,
   input  logic              nz_we,
   input  logic [7:0]        nz_val,
   input  logic [WORD_W-1:0] nz_col,
   input  logic              nz_ipv,
   output logic              nz_full,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_rows,
   input  logic [WORD_W-1:0] cfg_cols,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              tx_valid,
   output logic [7:0]        tx_val,
   output logic              tx_ipv,
   output logic [2:0]        tx_col
);
   tx_state_e         state_q, state_d;
   logic [NZ_CW-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] cols_q, cols_d;
   logic [NZ_CW-1:0]  n_q, n_d;
   logic [NZ_CW-1:0]  pad_q, pad_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              tx_valid_q, tx_valid_d;
   word_t             tx_w_q, tx_w_d;

   logic [7:0]        vec_mem [VEC_DEPTH];
   logic [7:0]        vec_rdata_q;
   logic [VA_W-1:0]   vec_raddr;

   logic [NZ_EW-1:0]  nz_rdata;
   nz_ent_t           nz_rd;
   logic [NZ_CW-1:0]  nz_count;
   logic              nz_rd_first, nz_rd_next, nz_clr;
   logic              cols_ok;

   smvm_nz_buffer u_nz (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (nz_we && !busy_q),
      .wr_data  ({nz_val, nz_ipv, nz_col}),
      .clr      (nz_clr),
      .rd_first (nz_rd_first),
      .rd_next  (nz_rd_next),
      .rd_data  (nz_rdata),
      .count    (nz_count),
      .full     (nz_full)
   );

   assign nz_rd = nz_ent_t'(nz_rdata);

   // Vector RAM is read two entries ahead of the bus so vec[i] is ready when VEC(i) is registered.
   always_ff @(posedge clk) begin
      if (vec_we && !busy_q) vec_mem[vec_addr] <= vec_wdata;
      vec_rdata_q <= vec_mem[vec_raddr];
   end

   assign cols_ok = (cfg_cols != '0) && (cfg_cols <= WORD_W'(VEC_DEPTH));

   // Outputs are computed for the state being entered, so every bus signal comes from a flop.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cols_d      = cols_q;
      n_d         = n_q;
      pad_d       = pad_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      tx_valid_d  = 1'b0;
      tx_w_d      = '0;
      vec_raddr   = '0;
      nz_rd_first = 1'b0;
      nz_rd_next  = 1'b0;
      nz_clr      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cols_ok) begin
                  cols_d      = cfg_cols;
                  n_d         = nz_count;
                  pad_d       = calc_pad(nz_count);
                  busy_d      = 1'b1;
                  nz_rd_first = 1'b1;
                  tx_valid_d  = 1'b1;
                  tx_w_d      = word_split(cfg_rows);
                  state_d     = S_HDR_R;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_HDR_R: begin
            vec_raddr  = '0;
            tx_valid_d = 1'b1;
            tx_w_d     = word_split(cols_q);
            state_d    = S_HDR_C;
         end
         S_HDR_C: begin
            vec_raddr  = VA_W'(1);
            tx_valid_d = 1'b1;
            tx_w_d     = '{val: vec_rdata_q, ipv: 1'b0, col: 3'b0};
            cnt_d      = '0;
            state_d    = S_VEC;
         end
         S_VEC: begin
            vec_raddr = cnt_q[VA_W-1:0] + VA_W'(2);
            if (WORD_W'(cnt_q) + WORD_W'(1) == cols_q) begin
               cnt_d = '0;
               if (n_q != '0) begin
                  tx_valid_d = 1'b1;
                  tx_w_d     = '{val: nz_rd.val, ipv: nz_rd.ipv, col: 3'b0};
                  state_d    = S_NZ_V;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
               cnt_d      = cnt_q + NZ_CW'(1);
               tx_valid_d = 1'b1;
               tx_w_d     = '{val: vec_rdata_q, ipv: 1'b0, col: 3'b0};
            end
         end
         S_NZ_V: begin
            nz_rd_next = 1'b1;
            tx_valid_d = 1'b1;
            tx_w_d     = word_split(nz_rd.col);
            state_d    = S_NZ_I;
         end
         S_NZ_I: begin
            if (cnt_q + NZ_CW'(1) == n_q) begin
               cnt_d = '0;
               if (pad_q != '0) begin
                  tx_valid_d = 1'b1;
                  state_d    = S_PAD_V;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
               cnt_d      = cnt_q + NZ_CW'(1);
               tx_valid_d = 1'b1;
               tx_w_d     = '{val: nz_rd.val, ipv: nz_rd.ipv, col: 3'b0};
               state_d    = S_NZ_V;
            end
         end
         S_PAD_V: begin
            tx_valid_d = 1'b1;
            state_d    = S_PAD_I;
         end
         S_PAD_I: begin
            if (cnt_q + NZ_CW'(1) == pad_q) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d      = cnt_q + NZ_CW'(1);
               tx_valid_d = 1'b1;
               state_d    = S_PAD_V;
            end
         end
         S_GAP: begin
            if (cnt_q == NZ_CW'(GAP_CYCLES - 1)) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               nz_clr  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + NZ_CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cols_q     <= '0;
         n_q        <= '0;
         pad_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_w_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cols_q     <= cols_d;
         n_q        <= n_d;
         pad_q      <= pad_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         tx_valid_q <= tx_valid_d;
         tx_w_q     <= tx_w_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign tx_valid = tx_valid_q;
   assign tx_val   = tx_w_q.val;
   assign tx_ipv   = tx_w_q.ipv;
   assign tx_col   = tx_w_q.col;
endmodule

// File: tb/tb_smvm_stream_tx.sv
// Scenario bench for smvm_stream_tx: expected bus words come from a queue model of the stream format.
module tb_smvm_stream_tx;
   localparam int TB_K   = 4;
   localparam int TB_GAP = 8;
   localparam int TB_NZ  = 256;

   logic        clk, rst_n;
   logic        vec_we;
   logic [6:0]  vec_addr;
   logic [7:0]  vec_wdata;
   logic        nz_we;
   logic [7:0]  nz_val;
   logic [11:0] nz_col;
   logic        nz_ipv;
   logic        nz_full;
   logic        start;
   logic [11:0] cfg_rows, cfg_cols;
   logic        busy, done, err;
   logic        tx_valid;
   logic [7:0]  tx_val;
   logic        tx_ipv;
   logic [2:0]  tx_col;

   smvm_stream_tx dut (
      .clk(clk), .rst_n(rst_n),
      .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
      .nz_we(nz_we), .nz_val(nz_val), .nz_col(nz_col), .nz_ipv(nz_ipv), .nz_full(nz_full),
      .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
      .busy(busy), .done(done), .err(err),
      .tx_valid(tx_valid), .tx_val(tx_val), .tx_ipv(tx_ipv), .tx_col(tx_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  val;
      logic [11:0] col;
      logic        ipv;
   } ent_t;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  vec_m [128];
   ent_t        nz_q [$];
   logic [11:0] exp_q [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_vec(input int a, input logic [7:0] d);
      vec_we = 1'b1; vec_addr = 7'(a); vec_wdata = d;
      tick();
      vec_we = 1'b0;
      vec_m[a] = d;
   endtask

   task automatic push_nz(input logic [7:0] v, input logic [11:0] c, input logic ip);
      ent_t e;
      nz_we = 1'b1; nz_val = v; nz_col = c; nz_ipv = ip;
      tick();
      nz_we = 1'b0;
      e.val = v; e.col = c; e.ipv = ip;
      if (nz_q.size() < TB_NZ) nz_q.push_back(e);
   endtask

   task automatic build_expected(input logic [11:0] rows, input logic [11:0] cols);
      int pad;
      exp_q.delete();
      exp_q.push_back(rows);
      exp_q.push_back(cols);
      for (int i = 0; i < int'(cols); i++) exp_q.push_back({vec_m[i], 4'b0000});
      foreach (nz_q[i]) begin
         exp_q.push_back({nz_q[i].val, nz_q[i].ipv, 3'b000});
         exp_q.push_back(nz_q[i].col);
      end
      pad = (TB_K - (nz_q.size() % TB_K)) % TB_K;
      for (int i = 0; i < 2 * pad; i++) exp_q.push_back(12'h000);
   endtask

   // poke >= 0 raises start (with a different config) at that burst index while busy.
   task automatic run_job(input string name, input logic [11:0] rows, input logic [11:0] cols,
                          input int poke);
      build_expected(rows, cols);
      start = 1'b1; cfg_rows = rows; cfg_cols = cols;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (tx_valid !== 1'b1 || busy !== 1'b1 || err !== 1'b0 ||
             {tx_val, tx_ipv, tx_col} !== exp_q[i]) begin
            errors++;
            $display("FAIL %s word %0d: valid=%b busy=%b err=%b W=%h, expected valid=1 busy=1 err=0 W=%h",
                     name, i, tx_valid, busy, err, {tx_val, tx_ipv, tx_col}, exp_q[i]);
         end
         start = (i == poke);
         if (i == poke) begin cfg_rows = 12'($urandom); cfg_cols = 12'd1; end
         tick();
      end
      start = 1'b0;
      for (int g = 0; g < TB_GAP; g++) begin
         checks++;
         if (tx_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s gap %0d: valid=%b done=%b err=%b busy=%b, expected 0 0 0 1",
                     name, g, tx_valid, done, err, busy);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s done: done=%b busy=%b valid=%b, expected 1 0 0", name, done, busy, tx_valid);
      end
      tick();
      checks++;
      if (done !== 1'b0 || nz_full !== 1'b0) begin
         errors++;
         $display("FAIL %s after-done: done=%b nz_full=%b, expected 0 0", name, done, nz_full);
      end
      nz_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      vec_we = 0; vec_addr = 0; vec_wdata = 0;
      nz_we = 0; nz_val = 0; nz_col = 0; nz_ipv = 0;
      start = 0; cfg_rows = 0; cfg_cols = 0;
      tick(); tick();
      checks++;
      if ({tx_valid, tx_val, tx_ipv, tx_col, busy, done, err, nz_full} !== '0) begin
         errors++;
         $display("FAIL reset: outputs=%b, expected all zero",
                  {tx_valid, tx_val, tx_ipv, tx_col, busy, done, err, nz_full});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      write_vec(0, 8'd5); write_vec(1, 8'hFD); write_vec(2, 8'd7);
      push_nz(8'd4, 12'd0, 1'b1);
      push_nz(8'hFE, 12'd2, 1'b0);
      run_job("basic", 12'd2, 12'd3, -1);
   endtask

   task automatic test_no_pad();
      write_vec(0, 8'($urandom));
      for (int i = 0; i < 4; i++) push_nz(8'($urandom), 12'($urandom), 1'($urandom));
      run_job("no_pad", 12'($urandom), 12'd1, -1);
   endtask

   task automatic test_no_nz();
      write_vec(0, 8'($urandom)); write_vec(1, 8'($urandom));
      run_job("no_nz", 12'd9, 12'd2, -1);
   endtask

   task automatic test_bad_cols();
      logic [11:0] bad [2];
      bad[0] = 12'd0; bad[1] = 12'd129;
      for (int b = 0; b < 2; b++) begin
         start = 1'b1; cfg_cols = bad[b]; cfg_rows = 12'd3;
         tick();
         start = 1'b0;
         checks++;
         if (err !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_cols %0d: err=%b busy=%b valid=%b, expected 1 0 0", bad[b], err, busy, tx_valid);
         end
         tick();
         checks++;
         if (err !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_cols %0d next: err=%b busy=%b valid=%b, expected 0 0 0", bad[b], err, busy, tx_valid);
         end
      end
   endtask

   task automatic test_busy_start();
      for (int i = 0; i < 5; i++) write_vec(i, 8'($urandom));
      for (int i = 0; i < 3; i++) push_nz(8'($urandom), 12'($urandom), 1'($urandom));
      run_job("busy_start", 12'd7, 12'd5, 3);
   endtask

   task automatic test_full();
      write_vec(0, 8'($urandom));
      for (int i = 0; i < TB_NZ + 1; i++) begin
         push_nz(8'($urandom), 12'($urandom), 1'($urandom));
         if (i == TB_NZ - 2 || i == TB_NZ - 1 || i == TB_NZ) begin
            checks++;
            if (nz_full !== (i >= TB_NZ - 1)) begin
               errors++;
               $display("FAIL full after %0d writes: nz_full=%b, expected %b", i + 1, nz_full, i >= TB_NZ - 1);
            end
         end
      end
      run_job("full", 12'd256, 12'd1, -1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20; i++) write_vec(i, 8'($urandom));
      for (int i = 0; i < 3; i++) push_nz(8'($urandom), 12'($urandom), 1'($urandom));
      start = 1'b1; cfg_rows = 12'd4; cfg_cols = 12'd20;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (tx_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid pre: valid=%b, expected 1", tx_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid async: valid=%b busy=%b, expected 0 0", tx_valid, busy);
      end
      tick();
      rst_n = 1'b1;
      nz_q.delete();
      tick();
      for (int i = 0; i < 2; i++) push_nz(8'($urandom), 12'($urandom), 1'($urandom));
      run_job("after_reset", 12'd11, 12'd20, -1);
   endtask

   task automatic test_random();
      int cols, n;
      for (int j = 0; j < 5; j++) begin
         cols = (j == 4) ? 128 : int'($urandom_range(1, 16));
         n    = int'($urandom_range(0, 9));
         for (int i = 0; i < cols; i++) write_vec(i, 8'($urandom));
         for (int i = 0; i < n; i++) push_nz(8'($urandom), 12'($urandom), 1'($urandom));
         run_job($sformatf("random%0d", j), 12'($urandom), 12'(cols), -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_no_pad();
      test_no_nz();
      test_bad_cols();
      test_busy_start();
      test_full();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
